alu_cmd_issuer: RTL and testbench

Upstream feeder for the 2-bit-opcode ALU, which takes signed 4-bit A/B and produces a signed 5-bit C with one registered cycle of latency.
- Accepts {opcode, A, B} commands over a valid/ready handshake and buffers them in a CMD_DEPTH-entry FIFO.
- Issues at most one command per cycle to the ALU and captures the matching C one cycle later.
- Returns {opcode, C} through a 2-entry result buffer with its own valid/ready handshake, so downstream backpressure never loses an ALU result.

---
 rtl/alu_cmd_issuer.sv | 115 +++++++++++
 tb/tb_alu_cmd_issuer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_issuer.sv
// rtl/alu_cmd_issuer.sv - command FIFO, single-issue ALU feeder and 2-entry result buffer
// Results are credit-gated so every issued command has a guaranteed result slot.
module alu_cmd_issuer #(
  parameter int CMD_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] in_opcode,
  input  logic [3:0] in_a,
  input  logic [3:0] in_b,
  output logic [1:0] alu_opcode,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  input  logic [4:0] alu_c,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [1:0] out_opcode,
  output logic [4:0] out_c
);

  localparam int PW = $clog2(CMD_DEPTH);
  localparam logic [PW:0] FULL_COUNT = CMD_DEPTH[PW:0];

  logic [9:0]    cmd_mem [CMD_DEPTH];
  logic [PW-1:0] cmd_wr;
  logic [PW-1:0] cmd_rd;
  logic [PW:0]   cmd_count;
  logic [9:0]    cmd_head;
  logic          cmd_full;
  logic          cmd_empty;
  logic          push;
  logic          issue;

  logic          inflight;
  logic [1:0]    inflight_op;

  logic [6:0]    res_mem [2];
  logic          res_wr;
  logic          res_rd;
  logic [1:0]    res_count;
  logic [2:0]    res_credit;
  logic          res_pop;

  assign cmd_full  = (cmd_count == FULL_COUNT);
  assign cmd_empty = (cmd_count == '0);
  assign in_ready  = !cmd_full && !reset;
  assign push      = in_valid && in_ready;
  assign cmd_head  = cmd_mem[cmd_rd];

  assign alu_opcode = cmd_empty ? 2'b00 : cmd_head[9:8];
  assign alu_a      = cmd_empty ? 4'b0000 : cmd_head[7:4];
  assign alu_b      = cmd_empty ? 4'b0000 : cmd_head[3:0];

  // Slots the buffer will hold after this edge if nothing new issues.
  assign res_pop    = out_valid && out_ready;
  assign res_credit = {1'b0, res_count} + {2'b00, inflight} - {2'b00, res_pop};
  assign issue      = !cmd_empty && (res_credit < 3'd2);

  always_ff @(posedge clk) begin
    if (push) cmd_mem[cmd_wr] <= {in_opcode, in_a, in_b};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_wr    <= '0;
      cmd_rd    <= '0;
      cmd_count <= '0;
    end else begin
      if (push)  cmd_wr <= cmd_wr + 1'b1;
      if (issue) cmd_rd <= cmd_rd + 1'b1;
      case ({push, issue})
        2'b10:   cmd_count <= cmd_count + 1'b1;
        2'b01:   cmd_count <= cmd_count - 1'b1;
        default: cmd_count <= cmd_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight    <= 1'b0;
      inflight_op <= 2'b00;
    end else begin
      inflight <= issue;
      if (issue) inflight_op <= cmd_head[9:8];
    end
  end

  // Capture never checks for space: the issue credit already reserved it.
  always_ff @(posedge clk) begin
    if (inflight) res_mem[res_wr] <= {inflight_op, alu_c};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_wr    <= 1'b0;
      res_rd    <= 1'b0;
      res_count <= 2'b00;
    end else begin
      if (inflight) res_wr <= ~res_wr;
      if (res_pop)  res_rd <= ~res_rd;
      case ({inflight, res_pop})
        2'b10:   res_count <= res_count + 1'b1;
        2'b01:   res_count <= res_count - 1'b1;
        default: res_count <= res_count;
      endcase
    end
  end

  assign out_valid = (res_count != 2'b00);
  assign {out_opcode, out_c} = out_valid ? res_mem[res_rd] : 7'b0;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// tb/tb_alu_cmd_issuer.sv - directed self-checking bench for alu_cmd_issuer
// Includes a registered reference ALU hooked to the alu_* ports.
module tb_alu_cmd_issuer;

  localparam int CMD_DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_opcode;
  logic [3:0] in_a;
  logic [3:0] in_b;
  logic [1:0] alu_opcode;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [4:0] alu_c;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_opcode;
  logic [4:0] out_c;

  int checks = 0;
  int errors = 0;
  int results_seen = 0;
  int seen0;
  logic [6:0] exp_q[$];

  alu_cmd_issuer #(.CMD_DEPTH(CMD_DEPTH)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_a(in_a), .in_b(in_b),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_c(out_c)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    case (alu_opcode)
      2'b00:   alu_c <= {alu_a[3], alu_a} + {alu_b[3], alu_b};
      2'b01:   alu_c <= {alu_a[3], alu_a} - {alu_b[3], alu_b};
      2'b10:   alu_c <= {~alu_a[3], ~alu_a};
      default: alu_c <= {4'b0000, |alu_b};
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      results_seen++;
      if (exp_q.size() == 0) check("unexpected_result", {25'b0, out_opcode, out_c}, 32'hffff_ffff);
      else check("result_order", {25'b0, out_opcode, out_c}, {25'b0, exp_q.pop_front()});
    end
    if (!reset && dut.res_count > 2'd2) check("res_count_le_2", {30'b0, dut.res_count}, 2);
    if (!reset && dut.cmd_count == CMD_DEPTH && in_ready) check("in_ready_when_full", {31'b0, in_ready}, 0);
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic push(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                      input logic [4:0] exp_c);
    int n = 0;
    in_valid = 1'b1; in_opcode = op; in_a = a; in_b = b;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("push_timeout", {31'b0, in_ready}, 1);
    else exp_q.push_back({op, exp_c});
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    @(negedge clk);
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) check(tag, {31'b0, out_valid}, 1);
  endtask

  task automatic drain();
    for (int n = 0; n < 100 && (exp_q.size() != 0 || out_valid); n++) @(negedge clk);
    check("drain_empty", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_opcode = 2'b00; in_a = 4'b0; in_b = 4'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", {31'b0, in_ready}, 0);
    check("rst_out_valid", {31'b0, out_valid}, 0);
    check("rst_out_c", {27'b0, out_c}, 0);
    check("rst_alu", {22'b0, alu_opcode, alu_a, alu_b}, 0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("in_ready_after_rst", {31'b0, in_ready}, 1);
    @(posedge clk); #1;

    // Add with minimum latency
    out_ready = 1'b1;
    push(2'b00, 4'd3, 4'd4, 5'd7);
    @(negedge clk); check("lat_e0", {31'b0, out_valid}, 0);
    @(negedge clk); check("lat_e1", {31'b0, out_valid}, 0);
    @(negedge clk); check("lat_e2", {31'b0, out_valid}, 1);
    check("add_c", {27'b0, out_c}, 5'd7);
    check("add_op", {30'b0, out_opcode}, 0);
    drain();

    // Sub then Not_A back-to-back
    push(2'b01, 4'b1100, 4'd5, 5'b10111);
    push(2'b10, 4'd5, 4'd3, 5'b11010);
    wait_valid("subnot_timeout");
    check("sub_c", {27'b0, out_c}, 5'b10111);
    @(negedge clk);
    check("not_valid", {31'b0, out_valid}, 1);
    check("not_c", {27'b0, out_c}, 5'b11010);
    check("not_op", {30'b0, out_opcode}, 2);
    drain();

    // Reduction OR of B
    push(2'b11, 4'd5, 4'd0, 5'd0);
    push(2'b11, 4'd5, 4'b1000, 5'd1);
    wait_valid("ror_timeout");
    check("ror0_c", {27'b0, out_c}, 0);
    @(negedge clk);
    check("ror1_c", {27'b0, out_c}, 1);
    drain();

    // Backpressure and full-FIFO release
    out_ready = 1'b0;
    seen0 = results_seen;
    fork
      begin
        push(2'b00, 4'd1, 4'd2, 5'd3);
        push(2'b01, 4'd7, 4'b1000, 5'b01111);
        push(2'b00, 4'b1000, 4'b1111, 5'b10111);
        push(2'b10, 4'b1000, 4'd0, 5'd7);
        push(2'b11, 4'd0, 4'd3, 5'd1);
        push(2'b00, 4'd7, 4'd7, 5'd14);
        push(2'b01, 4'd0, 4'd1, 5'b11111);
      end
      begin
        repeat (12) @(negedge clk);
        check("bp_in_ready", {31'b0, in_ready}, 0);
        check("bp_cmd_count", {29'b0, dut.cmd_count}, 4);
        check("bp_res_count", {30'b0, dut.res_count}, 2);
        check("bp_out_c", {27'b0, out_c}, 5'd3);
        check("bp_alu_head", {22'b0, alu_opcode, alu_a, alu_b}, {22'b0, 2'b00, 4'b1000, 4'b1111});
        repeat (2) @(negedge clk);
        check("bp_out_c_held", {27'b0, out_c}, 5'd3);
        check("bp_out_valid_held", {31'b0, out_valid}, 1);
        @(posedge clk); #1 out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_in_ready_freed", {31'b0, in_ready}, 1);
      end
    join
    drain();
    check("bp_result_count", results_seen - seen0, 7);

    // Reset mid-operation: 3 queued, 1 in flight, 1 buffered
    out_ready = 1'b0;
    push(2'b00, 4'd1, 4'd1, 5'd2);
    push(2'b00, 4'd2, 4'd2, 5'd4);
    push(2'b00, 4'd3, 4'd3, 5'd6);
    push(2'b01, 4'd0, 4'd0, 5'd0);
    push(2'b10, 4'd0, 4'd0, 5'b11111);
    push(2'b00, 4'd1, 4'd0, 5'd1);
    out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    check("pre_rst_inflight", {31'b0, dut.inflight}, 1);
    check("pre_rst_cmd_count", {29'b0, dut.cmd_count}, 3);
    #1 reset = 1'b1;
    #1;
    check("midrst_out_valid", {31'b0, out_valid}, 0);
    check("midrst_in_ready", {31'b0, in_ready}, 0);
    check("midrst_out_c", {27'b0, out_c}, 0);
    exp_q.delete();
    seen0 = results_seen;
    @(negedge clk);
    @(posedge clk); #2 reset = 1'b0;
    #1;
    check("postrst_in_ready", {31'b0, in_ready}, 1);
    check("postrst_out_valid", {31'b0, out_valid}, 0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    push(2'b00, 4'b1000, 4'b1000, 5'b10000);
    wait_valid("postrst_timeout");
    check("postrst_c", {27'b0, out_c}, 5'b10000);
    drain();
    check("postrst_result_count", results_seen - seen0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
